pong_duel_engine: RTL and testbench

- Parametrised two-player successor to the single-paddle pong graphics/animation generator: two paddles, one ball, serve/play/miss state machine and per-player score counters.
- Consumes pixel coordinates and pixel tick from vga_sync.
- Drives a registered RGB word of configurable width, so the top level needs no separate RGB buffer.

---
 rtl/pong_pkg.sv | 43 ++++
 rtl/pong_paddle_ctrl.sv | 60 ++++++
 rtl/pong_duel_engine.sv | 218 +++++++++++++++++++++
 tb/tb_pong_duel_engine.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the two-player pong engine.
//   pong_state_e : rally state machine states (SERVE, PLAY, MISS)
//   COORD_W      : pixel coordinate width (10 bits covers 640x480)
//   EXT_W        : widened coordinate width used for all comparisons, so that
//                  sums such as y + BALL_SZ never wrap
//   DEF_*_RGB    : default colours for ball, paddles and background
//   pong_dbg_t   : observation struct exported by the top for checkers
// -----------------------------------------------------------------------------
package pong_pkg;

  localparam int COORD_W = 10;
  localparam int EXT_W   = COORD_W + 1;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } pong_state_e;

  localparam logic [2:0] DEF_BALL_RGB = 3'b100;
  localparam logic [2:0] DEF_PAD_RGB  = 3'b010;
  localparam logic [2:0] DEF_BG_RGB   = 3'b000;

  // Snapshot of the engine's internal state. dx_neg/dy_neg are the sign bits
  // of the ball velocity; the magnitude is always BALL_V.
  typedef struct packed {
    pong_state_e        state;
    logic [COORD_W-1:0] ball_x;
    logic [COORD_W-1:0] ball_y;
    logic               dx_neg;
    logic               dy_neg;
    logic [COORD_W-1:0] lpad_top;
    logic [COORD_W-1:0] rpad_top;
  } pong_dbg_t;

  // Zero-extend a coordinate to the comparison width.
  function automatic logic [EXT_W-1:0] ext(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/pong_paddle_ctrl.sv
// -----------------------------------------------------------------------------
// pong_paddle_ctrl
// One vertical paddle: top-row register moved by up/down buttons once per
// frame, plus the pixel hit test for rendering. Horizontal placement is fixed
// by PAD_X.
//   clk, reset     : clock, synchronous active-low reset
//   refr_tick      : once-per-frame motion strobe
//   btn_up/down    : level buttons; both pressed means no motion
//   pix_x, pix_y   : current pixel
//   top            : paddle top row
//   pad_on         : current pixel lies on the paddle
// -----------------------------------------------------------------------------
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int V_RES = 480,
  parameter int PAD_H = 72,
  parameter int PAD_W = 4,
  parameter int PAD_V = 4,
  parameter int PAD_X = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               refr_tick,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [COORD_W-1:0] top,
  output logic               pad_on
);

  localparam logic [COORD_W-1:0] TOP0 = COORD_W'((V_RES - PAD_H) / 2);
  localparam logic [COORD_W-1:0] STEP = COORD_W'(PAD_V);
  localparam logic [EXT_W-1:0]   VR_E = EXT_W'(V_RES);
  localparam logic [EXT_W-1:0]   PH_E = EXT_W'(PAD_H);
  localparam logic [EXT_W-1:0]   PW_E = EXT_W'(PAD_W);
  localparam logic [EXT_W-1:0]   PX_E = EXT_W'(PAD_X);

  logic [EXT_W-1:0] top_e;
  assign top_e = ext(top);

  // A step that would cross either screen edge is dropped entirely rather
  // than clamped, so the paddle always sits on a multiple of PAD_V from TOP0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      top <= TOP0;
    end else if (refr_tick) begin
      if (btn_up && !btn_down && (top_e >= ext(STEP))) begin
        top <= top - STEP;
      end else if (btn_down && !btn_up && (top_e + PH_E + ext(STEP) <= VR_E)) begin
        top <= top + STEP;
      end
    end
  end

  assign pad_on = (ext(pix_x) >= PX_E) && (ext(pix_x) < PX_E + PW_E) &&
                  (ext(pix_y) >= top_e) && (ext(pix_y) < top_e + PH_E);

endmodule

// File: rtl/pong_duel_engine.sv
// -----------------------------------------------------------------------------
// pong_duel_engine
// Two-player pong: two paddles, one ball, SERVE/PLAY/MISS rally state machine,
// per-player scores and a registered RGB pixel output.
//   clk, reset   : clock, synchronous active-low reset
//   btn[3:0]     : {r_down, r_up, l_down, l_up}, level, debounced
//   video_on     : visible-area flag from vga_sync
//   p_tick       : pixel enable from vga_sync
//   pix_x, pix_y : current pixel
//   graph_rgb    : pixel colour, registered on p_tick (one pixel latency)
//   score_l/_r   : player scores, wrapping after SCORE_MAX
//   point_pulse  : one-cycle pulse per point scored
//   dbg          : state/ball/paddle snapshot
// All motion happens on refr_tick, the first pixel tick of line V_RES+1.
// -----------------------------------------------------------------------------
module pong_duel_engine
  import pong_pkg::*;
#(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int RGB_W        = 3,
  parameter int PAD_H        = 72,
  parameter int PAD_W        = 4,
  parameter int PAD_V        = 4,
  parameter int LPAD_X       = 32,
  parameter int RPAD_X       = 600,
  parameter int BALL_SZ      = 8,
  parameter int BALL_V       = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_MAX    = 9,
  parameter logic [RGB_W-1:0] BALL_RGB = RGB_W'(DEF_BALL_RGB),
  parameter logic [RGB_W-1:0] PAD_RGB  = RGB_W'(DEF_PAD_RGB),
  parameter logic [RGB_W-1:0] BG_RGB   = RGB_W'(DEF_BG_RGB)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         btn,
  input  logic               video_on,
  input  logic               p_tick,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  output logic [RGB_W-1:0]   graph_rgb,
  output logic [3:0]         score_l,
  output logic [3:0]         score_r,
  output logic               point_pulse,
  output pong_dbg_t          dbg
);

  localparam int                 CNT_W    = $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [COORD_W-1:0] BALL_X0  = COORD_W'((H_RES - BALL_SZ) / 2);
  localparam logic [COORD_W-1:0] BALL_Y0  = COORD_W'((V_RES - BALL_SZ) / 2);
  localparam logic [COORD_W-1:0] STEP     = COORD_W'(BALL_V);
  localparam logic [EXT_W-1:0]   HR_E     = EXT_W'(H_RES);
  localparam logic [EXT_W-1:0]   VR_E     = EXT_W'(V_RES);
  localparam logic [EXT_W-1:0]   BS_E     = EXT_W'(BALL_SZ);
  localparam logic [EXT_W-1:0]   BV_E     = EXT_W'(BALL_V);
  localparam logic [EXT_W-1:0]   LX_E     = EXT_W'(LPAD_X);
  localparam logic [EXT_W-1:0]   RX_E     = EXT_W'(RPAD_X);
  localparam logic [EXT_W-1:0]   PW_E     = EXT_W'(PAD_W);
  localparam logic [EXT_W-1:0]   PH_E     = EXT_W'(PAD_H);
  localparam logic [3:0]         SMAX     = 4'(SCORE_MAX);

  pong_state_e        state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [COORD_W-1:0] ball_x, ball_y, ball_x_n, ball_y_n;
  logic               dx_neg, dy_neg, dx_neg_n, dy_neg_n;
  logic [3:0]         score_l_n, score_r_n;
  logic               pulse_n;
  logic [COORD_W-1:0] lpad_top, rpad_top;
  logic               lpad_on, rpad_on, ball_on;
  logic               refr_tick;
  logic [EXT_W-1:0]   bx_e, by_e, lt_e, rt_e;
  logic               l_hit, r_hit;

  assign refr_tick = p_tick && (pix_y == COORD_W'(V_RES + 1)) && (pix_x == '0);

  pong_paddle_ctrl #(
    .V_RES(V_RES), .PAD_H(PAD_H), .PAD_W(PAD_W), .PAD_V(PAD_V), .PAD_X(LPAD_X)
  ) u_lpad (
    .clk(clk), .reset(reset), .refr_tick(refr_tick),
    .btn_up(btn[0]), .btn_down(btn[1]),
    .pix_x(pix_x), .pix_y(pix_y), .top(lpad_top), .pad_on(lpad_on)
  );

  pong_paddle_ctrl #(
    .V_RES(V_RES), .PAD_H(PAD_H), .PAD_W(PAD_W), .PAD_V(PAD_V), .PAD_X(RPAD_X)
  ) u_rpad (
    .clk(clk), .reset(reset), .refr_tick(refr_tick),
    .btn_up(btn[2]), .btn_down(btn[3]),
    .pix_x(pix_x), .pix_y(pix_y), .top(rpad_top), .pad_on(rpad_on)
  );

  assign bx_e = ext(ball_x);
  assign by_e = ext(ball_y);
  assign lt_e = ext(lpad_top);
  assign rt_e = ext(rpad_top);

  // Paddle contact uses the paddle positions from before this frame's move.
  // Left: ball's left edge inside the paddle's column. Right: ball's right
  // edge (x + BALL_SZ) inside the paddle's column.
  assign l_hit = (bx_e >= LX_E) && (bx_e <= LX_E + PW_E) &&
                 (by_e + BS_E > lt_e) && (by_e < lt_e + PH_E);
  assign r_hit = (bx_e + BS_E >= RX_E) && (bx_e + BS_E <= RX_E + PW_E) &&
                 (by_e + BS_E > rt_e) && (by_e < rt_e + PH_E);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ball_x_n  = ball_x;
    ball_y_n  = ball_y;
    dx_neg_n  = dx_neg;
    dy_neg_n  = dy_neg;
    score_l_n = score_l;
    score_r_n = score_r;
    pulse_n   = 1'b0;
    if (refr_tick) begin
      unique case (state)
        SERVE: begin
          if (cnt == CNT_LAST) begin
            cnt_n   = '0;
            state_n = PLAY;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        PLAY: begin
          if (by_e <= BV_E) begin
            dy_neg_n = 1'b0;
          end else if (by_e + BS_E >= VR_E - BV_E) begin
            dy_neg_n = 1'b1;
          end
          if (dx_neg && l_hit) begin
            dx_neg_n = 1'b0;
          end
          if (!dx_neg && r_hit) begin
            dx_neg_n = 1'b1;
          end
          // On a miss the ball freezes where it is; the next serve heads
          // toward the player who conceded.
          if (bx_e <= BV_E) begin
            score_r_n = (score_r == SMAX) ? 4'd0 : score_r + 4'd1;
            pulse_n   = 1'b1;
            dx_neg_n  = 1'b1;
            state_n   = MISS;
          end else if (bx_e + BS_E >= HR_E - BV_E) begin
            score_l_n = (score_l == SMAX) ? 4'd0 : score_l + 4'd1;
            pulse_n   = 1'b1;
            dx_neg_n  = 1'b0;
            state_n   = MISS;
          end else begin
            ball_x_n = dx_neg_n ? ball_x - STEP : ball_x + STEP;
            ball_y_n = dy_neg_n ? ball_y - STEP : ball_y + STEP;
          end
        end
        MISS: begin
          ball_x_n = BALL_X0;
          ball_y_n = BALL_Y0;
          dy_neg_n = 1'b0;
          cnt_n    = '0;
          state_n  = SERVE;
        end
        default: begin
          state_n = SERVE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= SERVE;
      cnt         <= '0;
      ball_x      <= BALL_X0;
      ball_y      <= BALL_Y0;
      dx_neg      <= 1'b0;
      dy_neg      <= 1'b0;
      score_l     <= '0;
      score_r     <= '0;
      point_pulse <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      ball_x      <= ball_x_n;
      ball_y      <= ball_y_n;
      dx_neg      <= dx_neg_n;
      dy_neg      <= dy_neg_n;
      score_l     <= score_l_n;
      score_r     <= score_r_n;
      point_pulse <= pulse_n;
    end
  end

  assign ball_on = (ext(pix_x) >= bx_e) && (ext(pix_x) <= bx_e + BS_E - EXT_W'(1)) &&
                   (ext(pix_y) >= by_e) && (ext(pix_y) <= by_e + BS_E - EXT_W'(1));

  // Ball is drawn over paddles; blanking forces black.
  always_ff @(posedge clk) begin
    if (!reset) begin
      graph_rgb <= '0;
    end else if (p_tick) begin
      if (!video_on) begin
        graph_rgb <= '0;
      end else if (ball_on) begin
        graph_rgb <= BALL_RGB;
      end else if (lpad_on || rpad_on) begin
        graph_rgb <= PAD_RGB;
      end else begin
        graph_rgb <= BG_RGB;
      end
    end
  end

  assign dbg = '{state: state, ball_x: ball_x, ball_y: ball_y,
                 dx_neg: dx_neg, dy_neg: dy_neg,
                 lpad_top: lpad_top, rpad_top: rpad_top};

endmodule

// File: tb/tb_pong_duel_engine.sv
// -----------------------------------------------------------------------------
// tb_pong_duel_engine
// Frame-level game model kept in plain integers (signed velocities, phase
// codes, modulo scores) checked against the engine every cycle, plus literal
// expectations for the reset state, serve timing, paddle limits, scoring,
// paddle bounce, score wrap and pixel colours.
// -----------------------------------------------------------------------------
module tb_pong_duel_engine;
  import pong_pkg::*;

  localparam int H_RES = 640, V_RES = 480, PAD_H = 72, PAD_W = 4, PAD_V = 4;
  localparam int LPAD_X = 32, RPAD_X = 600, BALL_SZ = 8, BALL_V = 2;
  localparam int SERVE_FRAMES = 60, SCORE_MAX = 9;
  localparam int PH_SERVE = 0, PH_PLAY = 1, PH_MISS = 2;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       video_on, p_tick;
  logic [9:0] pix_x, pix_y;
  logic [2:0] graph_rgb;
  logic [3:0] score_l, score_r;
  logic       point_pulse;
  pong_dbg_t  dbg;

  always #5 clk = ~clk;

  pong_duel_engine dut (
    .clk(clk), .reset(reset), .btn(btn), .video_on(video_on), .p_tick(p_tick),
    .pix_x(pix_x), .pix_y(pix_y), .graph_rgb(graph_rgb),
    .score_l(score_l), .score_r(score_r), .point_pulse(point_pulse), .dbg(dbg)
  );

  int n_checks = 0;
  int n_fail = 0;
  int pulse_seen = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase, m_cnt, m_bx, m_by, m_vx, m_vy, m_lt, m_rt, m_sl, m_sr, m_rgb;
  int m_pulse;

  function automatic bit in_box(int px, int py, int x, int y, int w, int h);
    return (px >= x) && (px < x + w) && (py >= y) && (py < y + h);
  endfunction

  function automatic int move_pad(int top, bit up, bit down);
    if (up && !down && top - PAD_V >= 0) return top - PAD_V;
    if (down && !up && top + PAD_V + PAD_H <= V_RES) return top + PAD_V;
    return top;
  endfunction

  function automatic bit overlaps(int by, int top);
    return (by < top + PAD_H) && (by + BALL_SZ > top);
  endfunction

  task automatic model_reset();
    m_phase = PH_SERVE; m_cnt = 0;
    m_bx = (H_RES - BALL_SZ) / 2; m_by = (V_RES - BALL_SZ) / 2;
    m_vx = BALL_V; m_vy = BALL_V;
    m_lt = (V_RES - PAD_H) / 2; m_rt = (V_RES - PAD_H) / 2;
    m_sl = 0; m_sr = 0; m_rgb = 0; m_pulse = 0;
  endtask

  task automatic model_frame(input logic [3:0] b);
    int nlt, nrt;
    nlt = move_pad(m_lt, b[0], b[1]);
    nrt = move_pad(m_rt, b[2], b[3]);
    case (m_phase)
      PH_SERVE: begin
        m_cnt++;
        if (m_cnt == SERVE_FRAMES) begin m_cnt = 0; m_phase = PH_PLAY; end
      end
      PH_PLAY: begin
        if (m_by <= BALL_V) m_vy = BALL_V;
        else if (m_by + BALL_SZ >= V_RES - BALL_V) m_vy = -BALL_V;
        if (m_vx < 0 && m_bx >= LPAD_X && m_bx <= LPAD_X + PAD_W && overlaps(m_by, m_lt))
          m_vx = BALL_V;
        else if (m_vx > 0 && m_bx + BALL_SZ >= RPAD_X && m_bx + BALL_SZ <= RPAD_X + PAD_W &&
                 overlaps(m_by, m_rt))
          m_vx = -BALL_V;
        if (m_bx <= BALL_V) begin
          m_sr = (m_sr + 1) % (SCORE_MAX + 1); m_pulse = 1; m_vx = -BALL_V; m_phase = PH_MISS;
        end else if (m_bx + BALL_SZ >= H_RES - BALL_V) begin
          m_sl = (m_sl + 1) % (SCORE_MAX + 1); m_pulse = 1; m_vx = BALL_V; m_phase = PH_MISS;
        end else begin
          m_bx += m_vx; m_by += m_vy;
        end
      end
      default: begin
        m_bx = (H_RES - BALL_SZ) / 2; m_by = (V_RES - BALL_SZ) / 2;
        m_vy = BALL_V; m_cnt = 0; m_phase = PH_SERVE;
      end
    endcase
    m_lt = nlt; m_rt = nrt;
  endtask

  // Applies the inputs that were present at the clock edge just taken.
  task automatic model_apply();
    m_pulse = 0;
    if (!reset) begin
      model_reset();
    end else begin
      if (p_tick) begin
        if (!video_on) m_rgb = 0;
        else if (in_box(int'(pix_x), int'(pix_y), m_bx, m_by, BALL_SZ, BALL_SZ)) m_rgb = 4;
        else if (in_box(int'(pix_x), int'(pix_y), LPAD_X, m_lt, PAD_W, PAD_H) ||
                 in_box(int'(pix_x), int'(pix_y), RPAD_X, m_rt, PAD_W, PAD_H)) m_rgb = 2;
        else m_rgb = 0;
      end
      if (p_tick && int'(pix_y) == V_RES + 1 && pix_x == 10'd0) model_frame(btn);
    end
  endtask

  function automatic int state_code(pong_state_e s);
    case (s)
      SERVE:   return PH_SERVE;
      PLAY:    return PH_PLAY;
      MISS:    return PH_MISS;
      default: return -1;
    endcase
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("graph_rgb", int'(graph_rgb), m_rgb);
      check("score_l", int'(score_l), m_sl);
      check("score_r", int'(score_r), m_sr);
      check("point_pulse", int'(point_pulse), m_pulse);
      check("state", state_code(dbg.state), m_phase);
      check("ball_x", int'(dbg.ball_x), m_bx);
      check("ball_y", int'(dbg.ball_y), m_by);
      check("dx_neg", int'(dbg.dx_neg), (m_vx < 0) ? 1 : 0);
      check("dy_neg", int'(dbg.dy_neg), (m_vy < 0) ? 1 : 0);
      check("lpad_top", int'(dbg.lpad_top), m_lt);
      check("rpad_top", int'(dbg.rpad_top), m_rt);
      if (point_pulse) pulse_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    model_apply();
  endtask

  task automatic frame(input logic [3:0] b);
    btn = b; p_tick = 1'b1; video_on = 1'b0; pix_x = 10'd0; pix_y = 10'(V_RES + 1);
    step();
    p_tick = 1'b0;
  endtask

  task automatic pixel(input int x, input int y, input logic vo);
    btn = 4'b0000; p_tick = 1'b1; video_on = vo; pix_x = 10'(x); pix_y = 10'(y);
    step();
    p_tick = 1'b0;
  endtask

  // Right paddle chases the ball; left paddle flees to the far half.
  function automatic logic [3:0] play_btns(bit track_r, bit avoid_l);
    logic [1:0] r, l;
    r = 2'b00; l = 2'b00;
    if (track_r) begin
      if (m_rt + PAD_H / 2 < m_by + BALL_SZ / 2 - 2) r = 2'b10;
      else if (m_rt + PAD_H / 2 > m_by + BALL_SZ / 2 + 2) r = 2'b01;
    end
    if (avoid_l) l = (m_by + BALL_SZ / 2 < V_RES / 2) ? 2'b10 : 2'b01;
    return {r, l};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    bit seen9;
    reset = 1'b0; btn = '0; video_on = 1'b0; p_tick = 1'b0; pix_x = '0; pix_y = '0;
    repeat (3) step();
    chk_en = 1'b1;
    check("rst_rgb", int'(graph_rgb), 0);
    check("rst_score_l", int'(score_l), 0);
    check("rst_score_r", int'(score_r), 0);
    check("rst_lpad", int'(dbg.lpad_top), 204);
    check("rst_rpad", int'(dbg.rpad_top), 204);
    check("rst_ball_x", int'(dbg.ball_x), 316);
    check("rst_ball_y", int'(dbg.ball_y), 236);
    check("rst_state", state_code(dbg.state), PH_SERVE);
    reset = 1'b1;
    step();

    // Left up for 60 frames: 204 -> 0 after 51 frames, then pinned. Serve ends.
    repeat (60) frame(4'b0001);
    check("lpad_top_limit", int'(dbg.lpad_top), 0);
    check("serve_done", state_code(dbg.state), PH_PLAY);
    check("serve_ball_x", int'(dbg.ball_x), 316);
    frame(4'b1111);
    check("both_btn_l", int'(dbg.lpad_top), 0);
    check("both_btn_r", int'(dbg.rpad_top), 204);
    check("first_move_x", int'(dbg.ball_x), 318);
    check("first_move_y", int'(dbg.ball_y), 238);

    // Right paddle parked at the top: ball exits right.
    p0 = pulse_seen;
    for (int i = 0; i < 400 && m_phase != PH_MISS; i++) frame(4'b0100);
    check("right_miss_state", state_code(dbg.state), PH_MISS);
    check("right_miss_score_l", int'(score_l), 1);
    check("right_miss_score_r", int'(score_r), 0);
    frame(4'b0000);
    check("after_miss_state", state_code(dbg.state), PH_SERVE);
    check("after_miss_dx", int'(dbg.dx_neg), 0);
    check("after_miss_ball_x", int'(dbg.ball_x), 316);
    check("one_pulse", pulse_seen - p0, 1);

    // Right paddle tracks the ball: bounce at x=592, then one step to 590.
    for (int i = 0; i < 460 && !(m_phase == PH_PLAY && m_vx < 0); i++) frame(play_btns(1'b1, 1'b0));
    check("rhit_dx", int'(dbg.dx_neg), 1);
    check("rhit_ball_x", int'(dbg.ball_x), 590);
    check("rhit_score_l", int'(score_l), 1);

    // Left keeps missing until score_r goes 9 -> 0.
    seen9 = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      frame(play_btns(1'b1, 1'b1));
      if (m_sr == 9 && !seen9) begin
        seen9 = 1'b1;
        check("score_r_nine", int'(score_r), 9);
      end
      if (seen9 && m_sr == 0) break;
    end
    check("wrap_seen9", int'(seen9), 1);
    check("score_r_wrap", int'(score_r), 0);
    check("wrap_pulse", int'(point_pulse), 1);
    check("wrap_state", state_code(dbg.state), PH_MISS);

    // Rendering around the centred ball (316..323, 236..243).
    frame(4'b0000);
    pixel(320, 240, 1'b1); check("rgb_ball", int'(graph_rgb), 4);
    pixel(316, 236, 1'b1); check("rgb_ball_corner", int'(graph_rgb), 4);
    pixel(323, 243, 1'b1); check("rgb_ball_far", int'(graph_rgb), 4);
    pixel(324, 240, 1'b1); check("rgb_right_of_ball", int'(graph_rgb), 0);
    pixel(315, 236, 1'b1); check("rgb_left_of_ball", int'(graph_rgb), 0);
    pixel(33, m_lt + 5, 1'b1); check("rgb_lpad", int'(graph_rgb), 2);
    pixel(320, 240, 1'b1);
    step(); check("rgb_hold", int'(graph_rgb), 4);
    pixel(320, 240, 1'b0); check("rgb_blank", int'(graph_rgb), 0);

    // Reset in the middle of PLAY.
    repeat (65) frame(4'b0000);
    check("pre_reset_state", state_code(dbg.state), PH_PLAY);
    reset = 1'b0; frame(4'b0000); reset = 1'b1;
    check("mid_rst_state", state_code(dbg.state), PH_SERVE);
    check("mid_rst_ball_x", int'(dbg.ball_x), 316);
    check("mid_rst_score_l", int'(score_l), 0);
    check("mid_rst_score_r", int'(score_r), 0);

    // Reset on the very edge that would score a right miss.
    for (int i = 0; i < 500 && !(m_phase == PH_PLAY && m_bx + BALL_SZ >= H_RES - BALL_V); i++)
      frame(4'b0000);
    check("pre_miss_x", int'(dbg.ball_x), 630);
    reset = 1'b0; frame(4'b0000); reset = 1'b1;
    check("rst_at_miss_pulse", int'(point_pulse), 0);
    check("rst_at_miss_score_l", int'(score_l), 0);
    step();
    check("rst_at_miss_pulse2", int'(point_pulse), 0);
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
